regfile_write_arbiter: RTL and testbench

Shares the register file's single write port between the in-order pipeline writeback stage and a long-latency unit (mul/div, late loads) that returns results out of step with the pipeline. It buffers long-latency results in a small FIFO and inserts them into idle writeback slots. It keeps a busy-bit scoreboard of destination registers with outstanding long-latency results and raises a decode hazard on RAW/WAW conflicts. It sits between MEM/WB, the long-latency unit, the ID stage and the register file write inputs.

---
 rtl/regfile_write_arbiter.sv | 129 ++++++++++++
 tb/tb_regfile_write_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Shares the register file write port between pipeline WB (0-cycle, priority) and a buffered long-latency unit
// (>=1 cycle, lu_ready_o = !full); a busy-bit scoreboard raises decode hazards and a starvation counter forces drain slots.
module regfile_write_arbiter #(
   parameter int address_width = 5,
   parameter int register_size = 32,
   parameter int fifo_depth    = 2,
   parameter int starve_limit  = 8
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     wb_we_i,
   input  logic [address_width-1:0] wb_addr_i,
   input  logic [register_size-1:0] wb_data_i,
   input  logic                     lu_valid_i,
   input  logic [address_width-1:0] lu_addr_i,
   input  logic [register_size-1:0] lu_data_i,
   output logic                     lu_ready_o,
   input  logic                     issue_i,
   input  logic [address_width-1:0] issue_addr_i,
   input  logic [address_width-1:0] rs1_addr_i,
   input  logic [address_width-1:0] rs2_addr_i,
   input  logic [address_width-1:0] rd_addr_i,
   output logic                     hazard_o,
   output logic                     wb_stall_o,
   output logic                     rf_we_o,
   output logic [address_width-1:0] rf_addr_o,
   output logic [register_size-1:0] rf_data_o
);

   localparam int num_regs = 2**address_width;
   localparam int ptr_w    = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
   localparam int cnt_w    = $clog2(fifo_depth + 1);
   localparam int starve_w = $clog2(starve_limit + 1);

   logic [address_width-1:0] fifo_addr [fifo_depth];
   logic [register_size-1:0] fifo_data [fifo_depth];
   logic [ptr_w-1:0]         rd_ptr;
   logic [ptr_w-1:0]         wr_ptr;
   logic [cnt_w-1:0]         count;
   logic [num_regs-1:0]      busy;
   logic [num_regs-1:0]      busy_next;
   logic [starve_w-1:0]      starve_cnt;

   logic                     fifo_empty;
   logic                     fifo_full;
   logic                     push;
   logic                     pop;
   logic                     wb_eff;
   logic                     blocked;
   logic [address_width-1:0] head_addr;
   logic [register_size-1:0] head_data;

   assign fifo_empty = (count == '0);
   assign fifo_full  = (count == cnt_w'(fifo_depth));
   assign head_addr  = fifo_addr[rd_ptr];
   assign head_data  = fifo_data[rd_ptr];
   assign wb_eff     = wb_we_i && (wb_addr_i != '0);

   // A forced drain slot overrides WB; otherwise WB wins and the FIFO takes idle slots.
   assign pop        = !fifo_empty && (wb_stall_o || !wb_eff);
   assign push       = lu_valid_i && !fifo_full;
   assign blocked    = !fifo_empty && !pop;
   assign lu_ready_o = !fifo_full;

   always_comb begin
      rf_we_o   = 1'b0;
      rf_addr_o = wb_addr_i;
      rf_data_o = wb_data_i;
      if (pop) begin
         rf_we_o   = (head_addr != '0);
         rf_addr_o = head_addr;
         rf_data_o = head_data;
      end else if (!wb_stall_o) begin
         rf_we_o   = wb_eff;
      end
   end

   // Set after clear so a same-cycle reissue of the drained register stays busy.
   always_comb begin
      busy_next = busy;
      if (pop && head_addr != '0)
         busy_next[head_addr] = 1'b0;
      if (issue_i && issue_addr_i != '0)
         busy_next[issue_addr_i] = 1'b1;
      busy_next[0] = 1'b0;
   end

   assign hazard_o = busy[rs1_addr_i] | busy[rs2_addr_i] | busy[rd_addr_i];

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_addr[wr_ptr] <= lu_addr_i;
         fifo_data[wr_ptr] <= lu_data_i;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         count      <= '0;
         busy       <= '0;
         starve_cnt <= '0;
         wb_stall_o <= 1'b0;
      end else begin
         if (push)
            wr_ptr <= (wr_ptr == ptr_w'(fifo_depth - 1)) ? '0 : wr_ptr + ptr_w'(1);
         if (pop)
            rd_ptr <= (rd_ptr == ptr_w'(fifo_depth - 1)) ? '0 : rd_ptr + ptr_w'(1);
         case ({push, pop})
            2'b10:   count <= count + cnt_w'(1);
            2'b01:   count <= count - cnt_w'(1);
            default: count <= count;
         endcase
         busy <= busy_next;

         wb_stall_o <= 1'b0;
         if (!blocked) begin
            starve_cnt <= '0;
         end else if (starve_cnt == starve_w'(starve_limit - 1)) begin
            starve_cnt <= '0;
            wb_stall_o <= 1'b1;
         end else begin
            starve_cnt <= starve_cnt + starve_w'(1);
         end
      end
   end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: inputs change 1 time unit after the rising edge,
// outputs are sampled 1 unit later, well before the next edge.
module tb_regfile_write_arbiter;

   logic        clk;
   logic        reset_n;
   logic        wb_we_i;
   logic [4:0]  wb_addr_i;
   logic [31:0] wb_data_i;
   logic        lu_valid_i;
   logic [4:0]  lu_addr_i;
   logic [31:0] lu_data_i;
   logic        lu_ready_o;
   logic        issue_i;
   logic [4:0]  issue_addr_i;
   logic [4:0]  rs1_addr_i;
   logic [4:0]  rs2_addr_i;
   logic [4:0]  rd_addr_i;
   logic        hazard_o;
   logic        wb_stall_o;
   logic        rf_we_o;
   logic [4:0]  rf_addr_o;
   logic [31:0] rf_data_o;

   int tests_run = 0;
   int tests_failed = 0;

   regfile_write_arbiter dut (
      .clk(clk), .reset_n(reset_n),
      .wb_we_i(wb_we_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
      .lu_valid_i(lu_valid_i), .lu_addr_i(lu_addr_i), .lu_data_i(lu_data_i), .lu_ready_o(lu_ready_o),
      .issue_i(issue_i), .issue_addr_i(issue_addr_i),
      .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i), .rd_addr_i(rd_addr_i),
      .hazard_o(hazard_o), .wb_stall_o(wb_stall_o),
      .rf_we_o(rf_we_o), .rf_addr_o(rf_addr_o), .rf_data_o(rf_data_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: time %0t reached, expected finish earlier", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      wb_we_i = 0; wb_addr_i = 0; wb_data_i = 0;
      lu_valid_i = 0; lu_addr_i = 0; lu_data_i = 0;
      issue_i = 0; issue_addr_i = 0;
      rs1_addr_i = 0; rs2_addr_i = 0; rd_addr_i = 0;
   endtask

   task automatic test_reset();
      reset_n = 0;
      idle_inputs();
      wb_we_i = 1; wb_addr_i = 5'd4; wb_data_i = 32'h44;
      rs1_addr_i = 5'd1; rs2_addr_i = 5'd2; rd_addr_i = 5'd3;
      #3;
      tests_run++;
      if (lu_ready_o !== 1'b1) begin tests_failed++; $display("FAIL reset_ready: got %b want 1", lu_ready_o); end
      tests_run++;
      if (hazard_o !== 1'b0) begin tests_failed++; $display("FAIL reset_hazard: got %b want 0", hazard_o); end
      tests_run++;
      if (wb_stall_o !== 1'b0) begin tests_failed++; $display("FAIL reset_stall: got %b want 0", wb_stall_o); end
      tests_run++;
      if (rf_we_o !== 1'b1 || rf_addr_o !== 5'd4 || rf_data_o !== 32'h44) begin
         tests_failed++;
         $display("FAIL reset_wb_pass: got we=%b addr=%0d data=%h want we=1 addr=4 data=44", rf_we_o, rf_addr_o, rf_data_o);
      end
      tick();
      reset_n = 1;
      idle_inputs();
      tick();
   endtask

   task automatic test_idle_lu();
      issue_i = 1; issue_addr_i = 5'd5;
      tick();
      issue_i = 0; rs1_addr_i = 5'd5;
      #1;
      tests_run++;
      if (hazard_o !== 1'b1) begin tests_failed++; $display("FAIL idle_hazard_set: got %b want 1", hazard_o); end
      tick();
      lu_valid_i = 1; lu_addr_i = 5'd5; lu_data_i = 32'hDEADBEEF;
      #1;
      tests_run++;
      if (lu_ready_o !== 1'b1 || rf_we_o !== 1'b0) begin
         tests_failed++; $display("FAIL idle_accept: got ready=%b we=%b want ready=1 we=0", lu_ready_o, rf_we_o);
      end
      tick();
      lu_valid_i = 0;
      #1;
      tests_run++;
      if (rf_we_o !== 1'b1 || rf_addr_o !== 5'd5 || rf_data_o !== 32'hDEADBEEF) begin
         tests_failed++;
         $display("FAIL idle_drain: got we=%b addr=%0d data=%h want we=1 addr=5 data=deadbeef", rf_we_o, rf_addr_o, rf_data_o);
      end
      tests_run++;
      if (hazard_o !== 1'b1) begin tests_failed++; $display("FAIL idle_hazard_drain_cycle: got %b want 1", hazard_o); end
      tick();
      #1;
      tests_run++;
      if (hazard_o !== 1'b0 || rf_we_o !== 1'b0) begin
         tests_failed++; $display("FAIL idle_after: got hazard=%b we=%b want 0 0", hazard_o, rf_we_o);
      end
      idle_inputs();
   endtask

   task automatic test_conflict();
      issue_i = 1; issue_addr_i = 5'd7;
      tick();
      issue_i = 0;
      lu_valid_i = 1; lu_addr_i = 5'd7; lu_data_i = 32'h22;
      wb_we_i = 1; wb_addr_i = 5'd3; wb_data_i = 32'h11;
      tick();
      lu_valid_i = 0;
      #1;
      tests_run++;
      if (rf_we_o !== 1'b1 || rf_addr_o !== 5'd3 || rf_data_o !== 32'h11) begin
         tests_failed++;
         $display("FAIL conflict_wb_first: got we=%b addr=%0d data=%h want we=1 addr=3 data=11", rf_we_o, rf_addr_o, rf_data_o);
      end
      tick();
      wb_we_i = 0; rd_addr_i = 5'd7;
      #1;
      tests_run++;
      if (rf_we_o !== 1'b1 || rf_addr_o !== 5'd7 || rf_data_o !== 32'h22) begin
         tests_failed++;
         $display("FAIL conflict_lu_next: got we=%b addr=%0d data=%h want we=1 addr=7 data=22", rf_we_o, rf_addr_o, rf_data_o);
      end
      tick();
      #1;
      tests_run++;
      if (hazard_o !== 1'b0 || rf_we_o !== 1'b0) begin
         tests_failed++; $display("FAIL conflict_after: got hazard=%b we=%b want 0 0", hazard_o, rf_we_o);
      end
      idle_inputs();
   endtask

   task automatic test_full();
      wb_we_i = 1; wb_addr_i = 5'd1; wb_data_i = 32'h1;
      lu_valid_i = 1; lu_addr_i = 5'd10; lu_data_i = 32'hA;
      #1;
      tests_run++;
      if (lu_ready_o !== 1'b1) begin tests_failed++; $display("FAIL full_first: got ready=%b want 1", lu_ready_o); end
      tick();
      lu_addr_i = 5'd11; lu_data_i = 32'hB;
      #1;
      tests_run++;
      if (lu_ready_o !== 1'b1) begin tests_failed++; $display("FAIL full_second: got ready=%b want 1", lu_ready_o); end
      tick();
      lu_addr_i = 5'd12; lu_data_i = 32'hC;
      #1;
      tests_run++;
      if (lu_ready_o !== 1'b0 || rf_addr_o !== 5'd1) begin
         tests_failed++; $display("FAIL full_third: got ready=%b addr=%0d want ready=0 addr=1", lu_ready_o, rf_addr_o);
      end
      tick();
      wb_we_i = 0;
      #1;
      tests_run++;
      if (lu_ready_o !== 1'b0 || rf_we_o !== 1'b1 || rf_addr_o !== 5'd10 || rf_data_o !== 32'hA) begin
         tests_failed++;
         $display("FAIL full_pop_cycle: got ready=%b we=%b addr=%0d data=%h want ready=0 we=1 addr=10 data=a",
                  lu_ready_o, rf_we_o, rf_addr_o, rf_data_o);
      end
      tick();
      #1;
      tests_run++;
      if (lu_ready_o !== 1'b1 || rf_addr_o !== 5'd11 || rf_data_o !== 32'hB) begin
         tests_failed++;
         $display("FAIL full_ready_rise: got ready=%b addr=%0d data=%h want ready=1 addr=11 data=b", lu_ready_o, rf_addr_o, rf_data_o);
      end
      tick();
      lu_valid_i = 0;
      #1;
      tests_run++;
      if (rf_we_o !== 1'b1 || rf_addr_o !== 5'd12 || rf_data_o !== 32'hC) begin
         tests_failed++;
         $display("FAIL full_third_drain: got we=%b addr=%0d data=%h want we=1 addr=12 data=c", rf_we_o, rf_addr_o, rf_data_o);
      end
      tick();
      idle_inputs();
   endtask

   task automatic test_starvation();
      int early_stalls;
      early_stalls = 0;
      wb_we_i = 1; wb_addr_i = 5'd2; wb_data_i = 32'h1234;
      lu_valid_i = 1; lu_addr_i = 5'd8; lu_data_i = 32'h88;
      tick();
      lu_valid_i = 0;
      for (int i = 0; i < 8; i++) begin
         #1;
         if (wb_stall_o !== 1'b0 || rf_addr_o !== 5'd2) early_stalls++;
         tick();
      end
      tests_run++;
      if (early_stalls != 0) begin
         tests_failed++; $display("FAIL starve_blocked: got %0d bad blocked cycles want 0", early_stalls);
      end
      #1;
      tests_run++;
      if (wb_stall_o !== 1'b1 || rf_we_o !== 1'b1 || rf_addr_o !== 5'd8 || rf_data_o !== 32'h88) begin
         tests_failed++;
         $display("FAIL starve_forced: got stall=%b we=%b addr=%0d data=%h want stall=1 we=1 addr=8 data=88",
                  wb_stall_o, rf_we_o, rf_addr_o, rf_data_o);
      end
      tick();
      #1;
      tests_run++;
      if (wb_stall_o !== 1'b0 || rf_we_o !== 1'b1 || rf_addr_o !== 5'd2 || rf_data_o !== 32'h1234) begin
         tests_failed++;
         $display("FAIL starve_held_wb: got stall=%b we=%b addr=%0d data=%h want stall=0 we=1 addr=2 data=1234",
                  wb_stall_o, rf_we_o, rf_addr_o, rf_data_o);
      end
      tick();
      idle_inputs();
   endtask

   task automatic test_race();
      issue_i = 1; issue_addr_i = 5'd9;
      tick();
      issue_i = 0;
      lu_valid_i = 1; lu_addr_i = 5'd9; lu_data_i = 32'h99;
      tick();
      lu_valid_i = 0;
      issue_i = 1; issue_addr_i = 5'd9; rd_addr_i = 5'd9;
      #1;
      tests_run++;
      if (rf_we_o !== 1'b1 || rf_addr_o !== 5'd9 || hazard_o !== 1'b1) begin
         tests_failed++;
         $display("FAIL race_drain: got we=%b addr=%0d hazard=%b want we=1 addr=9 hazard=1", rf_we_o, rf_addr_o, hazard_o);
      end
      tick();
      issue_i = 0;
      #1;
      tests_run++;
      if (hazard_o !== 1'b1) begin tests_failed++; $display("FAIL race_set_wins: got hazard=%b want 1", hazard_o); end
      idle_inputs();
   endtask

   task automatic test_reg0();
      rd_addr_i = 5'd9;
      lu_valid_i = 1; lu_addr_i = 5'd0; lu_data_i = 32'hFF;
      tick();
      lu_valid_i = 0;
      wb_we_i = 1; wb_addr_i = 5'd0; wb_data_i = 32'h55;
      #1;
      tests_run++;
      if (rf_we_o !== 1'b0 || rf_addr_o !== 5'd0) begin
         tests_failed++; $display("FAIL reg0_pop: got we=%b addr=%0d want we=0 addr=0", rf_we_o, rf_addr_o);
      end
      tick();
      #1;
      tests_run++;
      if (rf_we_o !== 1'b0 || hazard_o !== 1'b1) begin
         tests_failed++; $display("FAIL reg0_after: got we=%b hazard=%b want we=0 hazard=1", rf_we_o, hazard_o);
      end
      // Fill the FIFO behind busy WB traffic, then reset mid-drain.
      issue_i = 1; issue_addr_i = 5'd6;
      wb_we_i = 1; wb_addr_i = 5'd1; wb_data_i = 32'h1;
      lu_valid_i = 1; lu_addr_i = 5'd6; lu_data_i = 32'h66;
      tick();
      issue_i = 0; lu_addr_i = 5'd13; lu_data_i = 32'hDD;
      tick();
      lu_valid_i = 0; rs1_addr_i = 5'd6;
      #1;
      tests_run++;
      if (lu_ready_o !== 1'b0 || hazard_o !== 1'b1) begin
         tests_failed++; $display("FAIL reg0_prefill: got ready=%b hazard=%b want 0 1", lu_ready_o, hazard_o);
      end
      reset_n = 0;
      #1;
      tests_run++;
      if (lu_ready_o !== 1'b1 || hazard_o !== 1'b0 || rf_we_o !== 1'b1 || rf_addr_o !== 5'd1) begin
         tests_failed++;
         $display("FAIL reset_mid: got ready=%b hazard=%b we=%b addr=%0d want ready=1 hazard=0 we=1 addr=1",
                  lu_ready_o, hazard_o, rf_we_o, rf_addr_o);
      end
      tick();
      reset_n = 1;
      wb_we_i = 0;
      tick();
      #1;
      tests_run++;
      if (rf_we_o !== 1'b0 || lu_ready_o !== 1'b1) begin
         tests_failed++; $display("FAIL reset_mid_empty: got we=%b ready=%b want 0 1", rf_we_o, lu_ready_o);
      end
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_idle_lu();
      test_conflict();
      test_full();
      test_starvation();
      test_race();
      test_reg0();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
